// File: rtl/bsg_cover_pkg.sv
// Shared types and constants for the bsg_cover drain path.
//
// Contents:
//   state_e          drain arbiter FSM states (IDLE, HEADER, STREAM)
//   bsg_cover_hdr_s  24-bit header beat {src, els, len}; the top zero-pads it
//                    up to the stream width
//   hdr_*_lsb_lp     bit offsets of the header fields, for downstream unpackers
//   safe_clog2       clog2 that never returns 0, so index ports stay >= 1 bit
package bsg_cover_pkg;

   localparam int hdr_len_lsb_lp = 0;
   localparam int hdr_els_lsb_lp = 8;
   localparam int hdr_src_lsb_lp = 16;
   localparam int hdr_width_lp   = 24;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      STREAM
   } state_e;

   typedef struct packed {
      logic [7:0] src;
      logic [7:0] els;
      logic [7:0] len;
   } bsg_cover_hdr_s;

   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Combinational round-robin picker.
//
// Ports:
//   reqs       in   width_p      request vector
//   start      in   lg_width_lp  first index to consider; the search wraps
//   grant_v    out  1            at least one request is present
//   grant_idx  out  lg_width_lp  first requesting index at or after start
//
// The caller owns the priority state: it passes in where the search should
// begin and holds on to the winner itself.
module bsg_arb_round_robin
   import bsg_cover_pkg::*;
#(
   parameter int width_p     = 4,
   parameter int lg_width_lp = safe_clog2(width_p)
) (
   input  logic [width_p-1:0]     reqs,
   input  logic [lg_width_lp-1:0] start,
   output logic                   grant_v,
   output logic [lg_width_lp-1:0] grant_idx
);

   // Walk the requesters once, starting at 'start' and wrapping; first hit wins.
   always_comb begin
      int cand;
      cand      = 0;
      grant_v   = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < width_p; i++) begin
         cand = int'(start) + i;
         if (cand >= width_p) begin
            cand = cand - width_p;
         end
         if (!grant_v && reqs[cand[lg_width_lp-1:0]]) begin
            grant_v   = 1'b1;
            grant_idx = cand[lg_width_lp-1:0];
         end
      end
   end

endmodule

// File: rtl/bsg_cover_drain_arbiter.sv
// Merges num_cover_p bsg_cover drain ports into one coverage stream.
// Each transaction owns the stream from its header to its last beat.
//
// Ports:
//   clk_i       in   1                      ds-domain clock
//   reset_n_i   in   1                      synchronous active-low reset
//   v_i         in   num_cover_p            per-requester beat valid
//   last_i      in   num_cover_p            per-requester final-beat flag
//   data_i      in   num_cover_p*out_width  per-requester data, slice k = requester k
//   els_i       in   num_cover_p*8          per-requester CAM entry count
//   len_i       in   num_cover_p*8          per-requester beats per entry
//   ready_o     out  num_cover_p            per-requester ready
//   v_o         out  1                      downstream valid
//   data_o      out  out_width_p            downstream data (header or pass-through)
//   last_o      out  1                      downstream final beat of a transaction
//   ready_i     in   1                      downstream ready
//   busy_o      out  1                      a transaction is in progress
//   err_o       out  1                      sticky beat-count mismatch
//   txn_cnt_o   out  16                     completed transactions, wrapping
module bsg_cover_drain_arbiter
   import bsg_cover_pkg::*;
#(
   parameter  int num_cover_p     = 4,
   parameter  int out_width_p     = 32,
   localparam int lg_num_cover_lp = safe_clog2(num_cover_p)
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_cover_p-1:0]           v_i,
   input  logic [num_cover_p-1:0]           last_i,
   input  logic [num_cover_p*out_width_p-1:0] data_i,
   input  logic [num_cover_p*8-1:0]         els_i,
   input  logic [num_cover_p*8-1:0]         len_i,
   output logic [num_cover_p-1:0]           ready_o,
   output logic                             v_o,
   output logic [out_width_p-1:0]           data_o,
   output logic                             last_o,
   input  logic                             ready_i,
   output logic                             busy_o,
   output logic                             err_o,
   output logic [15:0]                      txn_cnt_o
);

   state_e                     state_q;
   logic [lg_num_cover_lp-1:0] grant_q;
   logic [lg_num_cover_lp-1:0] rr_q;
   logic [lg_num_cover_lp-1:0] rr_next;
   logic [lg_num_cover_lp-1:0] arb_idx;
   logic                       arb_v;
   logic [7:0]                 els_q;
   logic [7:0]                 len_q;
   logic [15:0]                expected_q;
   logic [15:0]                beat_cnt_q;
   logic [15:0]                beat_cnt_inc;
   logic [15:0]                txn_cnt_q;
   logic                       err_q;
   logic                       g_v;
   logic                       g_last;
   logic                       g_hs;
   bsg_cover_hdr_s             hdr;

   logic [out_width_p-1:0]     data_arr [num_cover_p];
   logic [7:0]                 els_arr  [num_cover_p];
   logic [7:0]                 len_arr  [num_cover_p];

   for (genvar k = 0; k < num_cover_p; k++) begin : g_unpack
      assign data_arr[k] = data_i[k*out_width_p +: out_width_p];
      assign els_arr[k]  = els_i[k*8 +: 8];
      assign len_arr[k]  = len_i[k*8 +: 8];
   end

   // rr_q holds the index the next search starts from, i.e. one past the last
   // grantee. Out of reset that is requester 0, so the first grant goes to 0.
   bsg_arb_round_robin #(
      .width_p     (num_cover_p),
      .lg_width_lp (lg_num_cover_lp)
   ) arb (
      .reqs      (v_i),
      .start     (rr_q),
      .grant_v   (arb_v),
      .grant_idx (arb_idx)
   );

   assign g_v          = v_i[grant_q];
   assign g_last       = last_i[grant_q];
   assign g_hs         = g_v & ready_i;
   assign beat_cnt_inc = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
   assign rr_next      = (grant_q == lg_num_cover_lp'(num_cover_p - 1)) ? '0 : grant_q + 1'b1;

   // Transaction FSM. The grant is taken only in IDLE and then held until the
   // owner's last beat, so late requests simply wait their turn.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         grant_q    <= '0;
         els_q      <= '0;
         len_q      <= '0;
         expected_q <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
         txn_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_v) begin
                  grant_q    <= arb_idx;
                  els_q      <= els_arr[arb_idx];
                  len_q      <= len_arr[arb_idx];
                  expected_q <= 16'(els_arr[arb_idx]) * 16'(len_arr[arb_idx]);
                  beat_cnt_q <= '0;
                  state_q    <= HEADER;
               end
            end
            HEADER: begin
               if (ready_i) begin
                  state_q <= STREAM;
               end
            end
            STREAM: begin
               if (g_hs) begin
                  beat_cnt_q <= beat_cnt_inc;
                  if (g_last) begin
                     if (beat_cnt_inc != expected_q) begin
                        err_q <= 1'b1;
                     end
                     txn_cnt_q <= txn_cnt_q + 16'd1;
                     rr_q      <= rr_next;
                     state_q   <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Header beat fields; the zero pad above bit 23 comes from the width cast.
   always_comb begin
      hdr     = '0;
      hdr.src = 8'(grant_q);
      hdr.els = els_q;
      hdr.len = len_q;
   end

   // Downstream view. STREAM is a pure wire-through of the granted port so the
   // owner sees the consumer's ready in the same cycle. Everything is forced
   // quiet while reset is held so no beat can be consumed during reset.
   always_comb begin
      v_o     = 1'b0;
      data_o  = '0;
      last_o  = 1'b0;
      ready_o = '0;
      if (reset_n_i) begin
         case (state_q)
            HEADER: begin
               v_o    = 1'b1;
               data_o = out_width_p'(hdr);
            end
            STREAM: begin
               v_o              = g_v;
               data_o           = data_arr[grant_q];
               last_o           = g_last;
               ready_o[grant_q] = ready_i;
            end
            default: ;
         endcase
      end
   end

   assign busy_o    = reset_n_i && (state_q != IDLE);
   assign err_o     = err_q;
   assign txn_cnt_o = txn_cnt_q;

endmodule
